// File: rtl/mmu_arb_if.sv
// rtl/mmu_arb_if.sv - client and memory handshake bundle for the mmu_arb arbiter

interface mmu_arb_if #(
    parameter int C_RPORT = 2,
    parameter int C_WPORT = 1,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 2
);
    logic [C_RPORT-1:0]        c_re;
    logic [C_RPORT*ADDR_W-1:0] c_raddr;
    logic [C_RPORT*LEN_W-1:0]  c_rlen;
    logic [C_RPORT*DATA_W-1:0] c_dout;
    logic [C_RPORT-1:0]        c_rack;
    logic [C_WPORT-1:0]        c_we;
    logic [C_WPORT*ADDR_W-1:0] c_waddr;
    logic [C_WPORT*LEN_W-1:0]  c_wlen;
    logic [C_WPORT*DATA_W-1:0] c_din;
    logic [C_WPORT-1:0]        c_wack;
    logic                      m_re;
    logic                      m_we;
    logic [ADDR_W-1:0]         m_addr;
    logic [LEN_W-1:0]          m_len;
    logic [DATA_W-1:0]         m_dout;
    logic [DATA_W-1:0]         m_din;
    logic                      m_rack;
    logic                      m_wack;

    modport slave (
        input  c_re, c_raddr, c_rlen, c_we, c_waddr, c_wlen, c_din, m_din, m_rack, m_wack,
        output c_dout, c_rack, c_wack, m_re, m_we, m_addr, m_len, m_dout
    );

    modport master (
        output c_re, c_raddr, c_rlen, c_we, c_waddr, c_wlen, c_din, m_din, m_rack, m_wack,
        input  c_dout, c_rack, c_wack, m_re, m_we, m_addr, m_len, m_dout
    );
endinterface

// File: rtl/mmu_arb.sv
// rtl/mmu_arb.sv - round-robin arbiter of client read/write ports onto one memory port

module mmu_arb #(
    parameter int C_RPORT = 2,
    parameter int C_WPORT = 1,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 2,
    parameter int WR_PRIO = 0
) (
    input  logic      clk,
    input  logic      rst,
    mmu_arb_if.slave  bus
);
    localparam int N  = C_RPORT + C_WPORT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR_WAIT = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [IW-1:0]             gnt_q, gnt_d;
    logic                      m_re_q, m_re_d;
    logic                      m_we_q, m_we_d;
    logic [ADDR_W-1:0]         m_addr_q, m_addr_d;
    logic [LEN_W-1:0]          m_len_q, m_len_d;
    logic [DATA_W-1:0]         m_dout_q, m_dout_d;
    logic [C_RPORT*DATA_W-1:0] c_dout_q, c_dout_d;
    logic [C_RPORT-1:0]        c_rack_q, c_rack_d;
    logic [C_WPORT-1:0]        c_wack_q, c_wack_d;

    logic [N-1:0]   elig;
    logic [2*N-1:0] elig2;
    logic [N-1:0]   rot;
    logic           found;
    int             sel;
    int             idx;
    int             nxt;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        m_re_d   = m_re_q;
        m_we_d   = m_we_q;
        m_addr_d = m_addr_q;
        m_len_d  = m_len_q;
        m_dout_d = m_dout_q;
        c_dout_d = c_dout_q;
        // Acks hold while the client keeps req high and drop once req is seen low.
        c_rack_d = c_rack_q & bus.c_re;
        c_wack_d = c_wack_q & bus.c_we;

        elig = {bus.c_we & ~c_wack_q, bus.c_re & ~c_rack_q};
        if (WR_PRIO != 0 && (|elig[N-1:C_RPORT])) begin
            elig[C_RPORT-1:0] = '0;
        end

        // Rotate so bit 0 is the pointer position; the first set bit is the winner.
        elig2 = {elig, elig};
        rot   = N'(elig2 >> ptr_q);
        found = 1'b0;
        sel   = 0;
        idx   = 0;
        nxt   = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = int'(ptr_q) + i;
                sel   = (idx >= N) ? idx - N : idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    nxt   = (sel + 1 >= N) ? 0 : sel + 1;
                    ptr_d = IW'(nxt);
                    gnt_d = IW'(sel);
                    if (sel < C_RPORT) begin
                        m_re_d  = 1'b1;
                        state_d = RD_WAIT;
                        for (int p = 0; p < C_RPORT; p++) begin
                            if (p == sel) begin
                                m_addr_d = bus.c_raddr[p*ADDR_W +: ADDR_W];
                                m_len_d  = bus.c_rlen[p*LEN_W +: LEN_W];
                            end
                        end
                    end else begin
                        m_we_d  = 1'b1;
                        state_d = WR_WAIT;
                        for (int p = 0; p < C_WPORT; p++) begin
                            if (p + C_RPORT == sel) begin
                                m_addr_d = bus.c_waddr[p*ADDR_W +: ADDR_W];
                                m_len_d  = bus.c_wlen[p*LEN_W +: LEN_W];
                                m_dout_d = bus.c_din[p*DATA_W +: DATA_W];
                            end
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (bus.m_rack) begin
                    m_re_d  = 1'b0;
                    state_d = IDLE;
                    // A client that abandoned its request still gets the data, but no ack.
                    for (int p = 0; p < C_RPORT; p++) begin
                        if (int'(gnt_q) == p) begin
                            c_dout_d[p*DATA_W +: DATA_W] = bus.m_din;
                            c_rack_d[p]                  = bus.c_re[p];
                        end
                    end
                end
            end
            WR_WAIT: begin
                if (bus.m_wack) begin
                    m_we_d  = 1'b0;
                    state_d = IDLE;
                    for (int p = 0; p < C_WPORT; p++) begin
                        if (int'(gnt_q) == p + C_RPORT) begin
                            c_wack_d[p] = bus.c_we[p];
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                m_re_d  = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            m_re_q   <= 1'b0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            m_len_q  <= '0;
            m_dout_q <= '0;
            c_dout_q <= '0;
            c_rack_q <= '0;
            c_wack_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            m_re_q   <= m_re_d;
            m_we_q   <= m_we_d;
            m_addr_q <= m_addr_d;
            m_len_q  <= m_len_d;
            m_dout_q <= m_dout_d;
            c_dout_q <= c_dout_d;
            c_rack_q <= c_rack_d;
            c_wack_q <= c_wack_d;
        end
    end

    assign bus.m_re   = m_re_q;
    assign bus.m_we   = m_we_q;
    assign bus.m_addr = m_addr_q;
    assign bus.m_len  = m_len_q;
    assign bus.m_dout = m_dout_q;
    assign bus.c_dout = c_dout_q;
    assign bus.c_rack = c_rack_q;
    assign bus.c_wack = c_wack_q;
endmodule

// File: tb/tb_mmu_arb.sv
// tb/tb_mmu_arb.sv - directed self-checking bench for mmu_arb

module tb_mmu_arb;
    localparam int CR = 2;
    localparam int CW = 1;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int LW = 2;
    localparam logic [63:0] PRIO_D = 64'hCAFE_0000_0000_0042;
    localparam logic [63:0] W_DATA = 64'h1122334455667788;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mmu_arb_if #(.C_RPORT(CR), .C_WPORT(CW), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) b0 ();
    mmu_arb_if #(.C_RPORT(CR), .C_WPORT(CW), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) b1 ();

    mmu_arb #(.C_RPORT(CR), .C_WPORT(CW), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .WR_PRIO(0))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    mmu_arb #(.C_RPORT(CR), .C_WPORT(CW), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .WR_PRIO(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        b0.c_re = '0; b0.c_raddr = '0; b0.c_rlen = '0; b0.c_we = '0; b0.c_waddr = '0;
        b0.c_wlen = '0; b0.c_din = '0; b0.m_din = '0; b0.m_rack = 1'b0; b0.m_wack = 1'b0;
        b1.c_re = '0; b1.c_raddr = '0; b1.c_rlen = '0; b1.c_we = '0; b1.c_waddr = '0;
        b1.c_wlen = '0; b1.c_din = '0; b1.m_din = '0; b1.m_rack = 1'b0; b1.m_wack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({b0.m_re, b0.m_we, b0.m_addr, b0.m_len, b0.m_dout, b0.c_rack, b0.c_wack} !== '0) begin
            tests_failed++;
            $display("FAIL reset_b0_outputs: got re=%b we=%b addr=%h rack=%b wack=%b, expected all 0",
                     b0.m_re, b0.m_we, b0.m_addr, b0.c_rack, b0.c_wack);
        end
        tests_run++;
        if (b0.c_dout !== '0 || b1.c_dout !== '0 || {b1.m_re, b1.m_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_dout: got b0=%h b1=%h, expected 0", b0.c_dout, b1.c_dout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        b0.c_raddr[31:0] = 32'h100;
        b0.c_rlen[1:0]   = 2'd3;
        b0.c_re[0]       = 1'b1;
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.m_we !== 1'b0 || b0.m_addr !== 32'h100 || b0.m_len !== 2'd3) begin
            tests_failed++;
            $display("FAIL single_read_issue: got re=%b we=%b addr=%h len=%0d, expected re=1 we=0 addr=100 len=3",
                     b0.m_re, b0.m_we, b0.m_addr, b0.m_len);
        end
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.c_rack !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_read_hold: got re=%b rack=%b, expected re=1 rack=00", b0.m_re, b0.c_rack);
        end
        b0.m_din  = 64'h0000_0000_DEAD_BEEF;
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        tests_run++;
        if (b0.c_rack !== 2'b01 || b0.c_dout[63:0] !== 64'hDEADBEEF || b0.m_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_read_done: got rack=%b dout=%h re=%b, expected rack=01 dout=deadbeef re=0",
                     b0.c_rack, b0.c_dout[63:0], b0.m_re);
        end
        tick();
        tests_run++;
        if (b0.c_rack !== 2'b01 || b0.m_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_read_ack_hold: got rack=%b re=%b, expected rack=01 re=0", b0.c_rack, b0.m_re);
        end
        b0.c_re[0] = 1'b0;
        tick();
        tests_run++;
        if (b0.c_rack !== 2'b00 || b0.c_dout[63:0] !== 64'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL single_read_ack_fall: got rack=%b dout=%h, expected rack=00 dout=deadbeef",
                     b0.c_rack, b0.c_dout[63:0]);
        end
    endtask

    task automatic test_round_robin();
        int port;
        int dropped;
        do_reset();
        b0.c_raddr = {32'h20, 32'h10};
        b0.c_waddr = 32'h30;
        b0.c_din   = W_DATA;
        b0.c_re    = 2'b11;
        b0.c_we    = 1'b1;
        dropped    = -1;
        for (int k = 0; k < 4; k++) begin
            port = (k == 3) ? 0 : k;
            tick();
            if (dropped == 2) b0.c_we[0] = 1'b1;
            else if (dropped >= 0) b0.c_re[dropped] = 1'b1;
            tests_run++;
            if (port < 2) begin
                if (b0.m_re !== 1'b1 || b0.m_we !== 1'b0 || b0.m_addr !== AW'(32'h10 * (port + 1))) begin
                    tests_failed++;
                    $display("FAIL rr_grant_%0d: got re=%b we=%b addr=%h, expected read of port %0d",
                             k, b0.m_re, b0.m_we, b0.m_addr, port);
                end
                b0.m_din  = 64'hA0 + 64'(k);
                b0.m_rack = 1'b1;
            end else begin
                if (b0.m_we !== 1'b1 || b0.m_re !== 1'b0 || b0.m_addr !== 32'h30 || b0.m_dout !== W_DATA) begin
                    tests_failed++;
                    $display("FAIL rr_grant_%0d: got re=%b we=%b addr=%h dout=%h, expected write w0",
                             k, b0.m_re, b0.m_we, b0.m_addr, b0.m_dout);
                end
                b0.m_wack = 1'b1;
            end
            tick();
            b0.m_rack = 1'b0;
            b0.m_wack = 1'b0;
            tests_run++;
            if (port < 2) begin
                if (b0.c_rack[port] !== 1'b1 || b0.c_dout[port*64 +: 64] !== 64'hA0 + 64'(k)) begin
                    tests_failed++;
                    $display("FAIL rr_ack_%0d: got rack=%b dout=%h, expected port %0d acked with %h",
                             k, b0.c_rack, b0.c_dout[port*64 +: 64], port, 64'hA0 + 64'(k));
                end
                if (k < 3) b0.c_re[port] = 1'b0;
            end else begin
                if (b0.c_wack !== 1'b1 || b0.m_we !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_ack_%0d: got wack=%b we=%b, expected wack=1 we=0", k, b0.c_wack, b0.m_we);
                end
                b0.c_we[0] = 1'b0;
            end
            dropped = port;
        end
        b0.c_re = '0;
        b0.c_we = '0;
        tick();
        tick();
        tests_run++;
        if (b0.c_rack !== 2'b00 || b0.c_wack !== 1'b0 || b0.m_re !== 1'b0 || b0.m_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_quiesce: got rack=%b wack=%b re=%b we=%b, expected all 0",
                     b0.c_rack, b0.c_wack, b0.m_re, b0.m_we);
        end
    endtask

    task automatic test_wr_prio();
        do_reset();
        b0.c_raddr[31:0] = 32'h50; b0.c_waddr = 32'h60; b0.c_re[0] = 1'b1; b0.c_we = 1'b1;
        b1.c_raddr[31:0] = 32'h50; b1.c_waddr = 32'h60; b1.c_re[0] = 1'b1; b1.c_we = 1'b1;
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.m_we !== 1'b0 || b0.m_addr !== 32'h50) begin
            tests_failed++;
            $display("FAIL prio0_first: got re=%b we=%b addr=%h, expected read r0 at 50",
                     b0.m_re, b0.m_we, b0.m_addr);
        end
        tests_run++;
        if (b1.m_we !== 1'b1 || b1.m_re !== 1'b0 || b1.m_addr !== 32'h60) begin
            tests_failed++;
            $display("FAIL prio1_first: got re=%b we=%b addr=%h, expected write w0 at 60",
                     b1.m_re, b1.m_we, b1.m_addr);
        end
        b0.m_din = PRIO_D; b0.m_rack = 1'b1; b1.m_wack = 1'b1;
        tick();
        b0.m_rack = 1'b0; b1.m_wack = 1'b0;
        tick();
        tests_run++;
        if (b0.m_we !== 1'b1 || b0.m_addr !== 32'h60 || b1.m_re !== 1'b1 || b1.m_addr !== 32'h50) begin
            tests_failed++;
            $display("FAIL prio_second: got b0 we=%b addr=%h b1 re=%b addr=%h, expected b0 w0 b1 r0",
                     b0.m_we, b0.m_addr, b1.m_re, b1.m_addr);
        end
        b0.m_wack = 1'b1; b1.m_rack = 1'b1;
        tick();
        b0.m_wack = 1'b0; b1.m_rack = 1'b0;
        b0.c_re = '0; b0.c_we = '0; b1.c_re = '0; b1.c_we = '0;
        tick();
        tick();
    endtask

    task automatic test_write();
        b0.c_waddr = 32'h2000;
        b0.c_din   = W_DATA;
        b0.c_wlen  = 2'd1;
        b0.c_we    = 1'b1;
        tick();
        tests_run++;
        if (b0.m_we !== 1'b1 || b0.m_re !== 1'b0 || b0.m_addr !== 32'h2000 || b0.m_len !== 2'd1 ||
            b0.m_dout !== W_DATA) begin
            tests_failed++;
            $display("FAIL write_issue: got we=%b re=%b addr=%h len=%0d dout=%h, expected we=1 addr=2000 len=1 dout=%h",
                     b0.m_we, b0.m_re, b0.m_addr, b0.m_len, b0.m_dout, W_DATA);
        end
        b0.m_din  = 64'hBAD0_BAD0_BAD0_BAD0;
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        tests_run++;
        if (b0.m_we !== 1'b1 || b0.c_wack !== 1'b0 || b0.c_rack !== 2'b00 || b0.c_dout !== {64'h0, PRIO_D}) begin
            tests_failed++;
            $display("FAIL write_stray_rack: got we=%b wack=%b rack=%b dout=%h, expected we=1 wack=0 rack=00",
                     b0.m_we, b0.c_wack, b0.c_rack, b0.c_dout);
        end
        b0.m_wack = 1'b1;
        tick();
        b0.m_wack = 1'b0;
        tests_run++;
        if (b0.c_wack !== 1'b1 || b0.m_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_done: got wack=%b we=%b, expected wack=1 we=0", b0.c_wack, b0.m_we);
        end
        b0.c_we = 1'b0;
        tick();
        tests_run++;
        if (b0.c_wack !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_ack_fall: got wack=%b, expected 0", b0.c_wack);
        end
    endtask

    task automatic test_reset_mid_read();
        b0.c_raddr[31:0] = 32'h300;
        b0.c_re[0]       = 1'b1;
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.m_addr !== 32'h300) begin
            tests_failed++;
            $display("FAIL midrst_issue: got re=%b addr=%h, expected re=1 addr=300", b0.m_re, b0.m_addr);
        end
        rst        = 1'b1;
        b0.c_re[0] = 1'b0;
        tick();
        tests_run++;
        if ({b0.m_re, b0.m_we, b0.m_addr, b0.m_len, b0.m_dout, b0.c_rack, b0.c_wack} !== '0 || b0.c_dout !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got re=%b we=%b addr=%h dout=%h cdout=%h, expected all 0",
                     b0.m_re, b0.m_we, b0.m_addr, b0.m_dout, b0.c_dout);
        end
        rst       = 1'b0;
        b0.m_din  = 64'h5555;
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        tests_run++;
        if (b0.c_rack !== 2'b00 || b0.c_dout !== '0 || b0.m_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_late_rack: got rack=%b dout=%h re=%b, expected 0", b0.c_rack, b0.c_dout, b0.m_re);
        end
        b0.c_raddr = {32'h500, 32'h400};
        b0.c_re    = 2'b11;
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.m_addr !== 32'h400) begin
            tests_failed++;
            $display("FAIL midrst_fresh: got re=%b addr=%h, expected r0 at 400", b0.m_re, b0.m_addr);
        end
        b0.m_din  = 64'h77;
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        tests_run++;
        if (b0.c_rack !== 2'b01 || b0.c_dout[63:0] !== 64'h77) begin
            tests_failed++;
            $display("FAIL midrst_fresh_ack: got rack=%b dout=%h, expected rack=01 dout=77",
                     b0.c_rack, b0.c_dout[63:0]);
        end
        b0.c_re[0] = 1'b0;
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.m_addr !== 32'h500) begin
            tests_failed++;
            $display("FAIL midrst_next: got re=%b addr=%h, expected r1 at 500", b0.m_re, b0.m_addr);
        end
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        b0.c_re   = '0;
        tick();
        tick();
    endtask

    task automatic test_hold_off();
        b0.c_raddr = {32'h600, 32'h700};
        b0.c_re[1] = 1'b1;
        tick();
        b0.m_din  = 64'h66;
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        tests_run++;
        if (b0.c_rack !== 2'b10 || b0.c_dout[127:64] !== 64'h66) begin
            tests_failed++;
            $display("FAIL holdoff_r1: got rack=%b dout1=%h, expected rack=10 dout1=66", b0.c_rack, b0.c_dout[127:64]);
        end
        b0.c_re[0] = 1'b1;
        tick();
        tests_run++;
        if (b0.m_re !== 1'b1 || b0.m_addr !== 32'h700 || b0.c_rack !== 2'b10) begin
            tests_failed++;
            $display("FAIL holdoff_r0_grant: got re=%b addr=%h rack=%b, expected r0 at 700 rack=10",
                     b0.m_re, b0.m_addr, b0.c_rack);
        end
        b0.m_din  = 64'h70;
        b0.m_rack = 1'b1;
        tick();
        b0.m_rack = 1'b0;
        tick();
        tests_run++;
        if (b0.c_rack !== 2'b11 || b0.m_re !== 1'b0 || b0.c_dout[63:0] !== 64'h70) begin
            tests_failed++;
            $display("FAIL holdoff_no_regrant: got rack=%b re=%b dout0=%h, expected rack=11 re=0 dout0=70",
                     b0.c_rack, b0.m_re, b0.c_dout[63:0]);
        end
        b0.c_re = '0;
        tick();
        tests_run++;
        if (b0.c_rack !== 2'b00) begin
            tests_failed++;
            $display("FAIL holdoff_release: got rack=%b, expected 00", b0.c_rack);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        zero_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_wr_prio();
        test_write();
        test_reset_mid_read();
        test_hold_off();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && (b0.m_re === 1'b1) && (b0.m_we === 1'b1)) begin
            tests_failed++;
            $display("FAIL mutex_b0: got m_re=1 m_we=1, expected never both");
        end
    end
endmodule
